// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: received word, strobes, busy.
interface uart_rx_if #(
   parameter int W = 8
);
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         rx_frame_err;
   logic         rx_busy;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_frame_err,
      output rx_busy
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input rx_frame_err,
      input rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, falling-edge start detect, mid-bit sampling,
// LSB-first payload, STOP_BITS stop bits with sticky framing-error flag.
module uart_rx #(
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 2,
   parameter int BAUD_RATE    = 115_200,
   parameter int CLK_FREQ     = 8_000_000
) (
   input  logic       clk,
   input  logic       rx_reset,
   input  logic       rx_serial,
   uart_rx_if.master  rx
);
   localparam int N  = CLK_FREQ / BAUD_RATE;
   localparam int H  = N / 2;
   localparam int CW = $clog2(N);
   localparam int BW = $clog2(PAYLOAD_BITS);
   localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

   localparam logic [CW-1:0] CNT_FULL  = CW'(N - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t state_q, state_d;

   logic s1_q, s2_q, s3_q;

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [SW-1:0]           stop_q, stop_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic                    err_q, err_d;

   logic [PAYLOAD_BITS-1:0] data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    ferr_q, ferr_d;
   logic                    busy_q, busy_d;

   logic start_edge;

   // s3 holds the previous s2 so a falling edge, not a low level, starts a frame
   always_ff @(posedge clk or posedge rx_reset) begin
      if (rx_reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= rx_serial;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign start_edge = s3_q & ~s2_q;

   always_ff @(posedge clk or posedge rx_reset) begin
      if (rx_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= '0;
         shift_q <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         err_q   <= err_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      err_d   = err_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start_edge) begin
               cnt_d   = '0;
               state_d = START;
               busy_d  = 1'b1;
            end
         end

         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!s2_q) begin
                  bit_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d          = '0;
               shift_d[bit_q] = s2_q;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  stop_d  = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (stop_q == STOP_LAST) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  ferr_d  = err_q | ~s2_q;
                  busy_d  = 1'b0;
                  err_d   = 1'b0;
                  stop_d  = '0;
                  state_d = IDLE;
               end else begin
                  err_d  = err_q | ~s2_q;
                  stop_d = stop_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            stop_d  = '0;
            err_d   = 1'b0;
         end
      endcase
   end

   assign rx.rx_data      = data_q;
   assign rx.rx_valid     = valid_q;
   assign rx.rx_frame_err = ferr_q;
   assign rx.rx_busy      = busy_q;
endmodule
